// File: rtl/dw_mac_unit.sv
// dw_mac_unit: depthwise-conv tap accumulator pairing weight/activation beats into KSIZE*KSIZE-tap window sums
// Result is held in a valid/ready output register; only the last tap of a window can stall on it.
module dw_mac_unit #(
    parameter int DW    = 32,
    parameter int KSIZE = 3,
    parameter int ACCW  = 2*DW+4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [DW-1:0]   w_data,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic signed [DW-1:0]   a_data,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic                   flush,
    output logic signed [ACCW-1:0] o_data,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic                   busy
);
    localparam int NT = KSIZE*KSIZE;
    localparam int CW = NT > 1 ? $clog2(NT) : 1;
    localparam logic [CW-1:0] LAST = CW'(NT-1);

    logic [CW-1:0]          tap_cnt;
    logic signed [ACCW-1:0] acc;
    logic                   last, stall, fire;
    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] sum;

    // The first tap of a window ignores acc, so acc never needs clearing between windows.
    always_comb begin
        last  = tap_cnt == LAST;
        stall = last & o_valid & ~o_ready;
        fire  = w_valid & a_valid & ~flush & ~stall & ~rst;
        prod  = w_data * a_data;
        sum   = (tap_cnt == '0 ? '0 : acc) + ACCW'(prod);
    end

    assign w_ready = fire;
    assign a_ready = fire;
    assign busy    = tap_cnt != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_cnt <= '0;
            acc     <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            if (flush) begin
                tap_cnt <= '0;
            end else if (fire) begin
                if (last) begin
                    o_data  <= sum;
                    tap_cnt <= '0;
                end else begin
                    acc     <= sum;
                    tap_cnt <= tap_cnt + CW'(1);
                end
            end
            o_valid <= (fire & last) | (o_valid & ~o_ready);
        end
    end
endmodule

// File: tb/tb_dw_mac_unit.sv
// tb_dw_mac_unit: vector table, hand sequences and random traffic checked against a window-queue model
module tb_dw_mac_unit;
    localparam int DW = 32, KSIZE = 3, NT = KSIZE*KSIZE, ACCW = 2*DW+4;

    logic clk = 1'b0, rst;
    logic signed [DW-1:0] w_data, a_data;
    logic w_valid, a_valid, flush, o_ready;
    logic w_ready, a_ready, o_valid, busy;
    logic signed [ACCW-1:0] o_data;

    int checks = 0, errors = 0, fires = 0;

    logic signed [ACCW-1:0] taps[$];
    logic                   mo_valid;
    logic signed [ACCW-1:0] mo_data;

    typedef struct {
        logic signed [DW-1:0]   w;
        logic signed [DW-1:0]   a;
        logic signed [ACCW-1:0] sum;
    } vec_t;
    vec_t tbl[5];

    dw_mac_unit #(.DW(DW), .KSIZE(KSIZE), .ACCW(ACCW)) dut (
        .clk(clk), .rst(rst),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .flush(flush),
        .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [ACCW-1:0] act, input logic signed [ACCW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic av, input logic signed [DW-1:0] w,
                         input logic signed [DW-1:0] a, input logic fl, input logic ordy);
        w_valid = wv; a_valid = av; w_data = w; a_data = a; flush = fl; o_ready = ordy;
    endtask

    task automatic model_reset();
        taps.delete();
        mo_valid = 1'b0;
        mo_data  = '0;
    endtask

    // One clock: check handshake before the edge, advance the model, check registered outputs after.
    task automatic tick();
        logic fe, done, ordy;
        logic signed [ACCW-1:0] p, s;
        #1;
        fe = w_valid & a_valid & ~flush & ~(taps.size() == NT-1 && mo_valid && !o_ready);
        chk("w_ready", ACCW'(w_ready), ACCW'(fe));
        chk("a_ready", ACCW'(a_ready), ACCW'(fe));
        p = ACCW'(w_data) * ACCW'(a_data);
        ordy = o_ready;
        done = 1'b0;
        @(posedge clk);
        if (flush) taps.delete();
        else if (fe) begin
            fires++;
            taps.push_back(p);
            if (taps.size() == NT) begin
                s = '0;
                foreach (taps[i]) s += taps[i];
                mo_data = s;
                done = 1'b1;
                taps.delete();
            end
        end
        mo_valid = done | (mo_valid & ~ordy);
        #1;
        chk("o_valid", ACCW'(o_valid), ACCW'(mo_valid));
        chk("o_data", o_data, mo_data);
        chk("busy", ACCW'(busy), ACCW'(taps.size() != 0));
    endtask

    task automatic window(input logic signed [DW-1:0] w, input logic signed [DW-1:0] a, input logic ordy);
        for (int i = 0; i < NT; i++) begin
            drive(1, 1, w, a, 0, ordy);
            tick();
        end
    endtask

    initial begin
        logic signed [ACCW-1:0] big;
        int f0, nv, first_v, last_v, idx;
        big = 1;
        big = 9 * ((big <<< 31) - (big <<< 62));
        tbl[0] = '{-32'sd3, 32'sd7, -68'sd189};
        tbl[1] = '{32'sh7FFFFFFF, 32'sh80000000, big};
        tbl[2] = '{32'sd2, 32'sd2, 68'sd36};
        tbl[3] = '{32'sd1000, -32'sd1, -68'sd9000};
        tbl[4] = '{32'sh80000000, 32'sh80000000, 68'sd9 * (68'sd1 <<< 62)};

        rst = 1'b1;
        drive(1, 1, 5, 5, 0, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w_ready", ACCW'(w_ready), 0);
        chk("rst_o_valid", ACCW'(o_valid), 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_busy", ACCW'(busy), 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1);

        // 1: ramp weights 1..9
        f0 = fires;
        for (int i = 1; i <= 9; i++) begin
            drive(1, 1, DW'(i), 1, 0, 1);
            tick();
        end
        chk("t1_fires", ACCW'(fires - f0), 9);
        chk("t1_valid", ACCW'(o_valid), 1);
        chk("t1_sum", o_data, 45);
        drive(0, 0, 0, 0, 0, 1);
        tick();
        chk("t1_drop", ACCW'(o_valid), 0);

        // 2: table vectors including extreme products
        foreach (tbl[k]) begin
            window(tbl[k].w, tbl[k].a, 1);
            chk("tbl_sum", o_data, tbl[k].sum);
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();

        // 3: stall on full output register, then back-to-back drain
        window(1, 1, 0);
        for (int i = 0; i < NT-1; i++) begin
            drive(1, 1, 2, 1, 0, 0);
            tick();
        end
        drive(1, 1, 2, 1, 0, 0);
        #1;
        chk("t3_stall", ACCW'(w_ready), 0);
        tick();
        chk("t3_hold", o_data, 9);
        o_ready = 1'b1;
        tick();
        chk("t3_b2b_valid", ACCW'(o_valid), 1);
        chk("t3_b2b_data", o_data, 18);
        drive(0, 0, 0, 0, 0, 1);
        tick();

        // 4: continuous streaming, one result every NT cycles
        f0 = fires; nv = 0; first_v = -1; last_v = -1;
        for (int c = 0; c < 4*NT; c++) begin
            drive(1, 1, $urandom, $urandom, 0, 1);
            tick();
            if (o_valid) begin
                nv++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
        end
        chk("t4_fires", ACCW'(fires - f0), 36);
        chk("t4_results", ACCW'(nv), 4);
        chk("t4_first", ACCW'(first_v), 8);
        chk("t4_last", ACCW'(last_v), 35);
        drive(0, 0, 0, 0, 0, 1);
        tick();

        // 5: activation gaps
        idx = 1;
        for (int c = 0; c < 40 && idx <= 9; c++) begin
            f0 = fires;
            drive(1, c[0], DW'(idx), 3, 0, 1);
            tick();
            if (fires != f0) idx++;
        end
        chk("t5_done", ACCW'(idx), 10);
        chk("t5_sum", o_data, 135);

        // 6: flush mid-window, then async reset mid-window
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 5, 5, 0, 1);
            tick();
        end
        drive(1, 1, 5, 5, 1, 1);
        tick();
        chk("t6_flush_busy", ACCW'(busy), 0);
        window(2, 2, 1);
        chk("t6_sum", o_data, 36);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 4, 4, 0, 0);
            tick();
        end
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", ACCW'(o_valid), 0);
        chk("t6_rst_data", o_data, 0);
        chk("t6_rst_busy", ACCW'(busy), 0);
        chk("t6_rst_ready", ACCW'(w_ready), 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // random traffic
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  c[2] ? DW'($urandom) : DW'($urandom_range(0, 20)) - 10,
                  c[3] ? DW'($urandom) : DW'($urandom_range(0, 20)) - 10,
                  $urandom_range(0, 30) == 0, $urandom_range(0, 2) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
